// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port burst-limited arbiter for one sync RAM; ports cpu_clk/rst, per-port req/we/adrs/wdata in with gnt/rvalid out, shared rdata, mem_address/mem_data/mem_wren out, mem_q in
module mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [8:0]  adrs0,
  input  logic [15:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  input  logic        req1,
  input  logic        we1,
  input  logic [8:0]  adrs1,
  input  logic [15:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rdata,
  output logic [8:0]  mem_address,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  input  logic [15:0] mem_q
);
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  logic       owner_q, owner_d;
  logic [3:0] burst_q, burst_d;
  logic [1:0] rd_tag_q, rd_tag_d;
  logic       sat, pick1, gnt;
  always_comb begin
    sat = burst_q >= MAXB;
    pick1 = (req0 & req1) ? (sat ? ~owner_q : owner_q) : req1;
    gnt1 = ~rst & pick1;
    gnt0 = ~rst & req0 & ~pick1;
    gnt = gnt0 | gnt1;
    mem_wren = gnt0 ? we0 : gnt1 & we1;
    mem_address = gnt0 ? adrs0 : gnt1 ? adrs1 : '0;
    mem_data = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    owner_d = gnt ? gnt1 : owner_q;
    burst_d = !gnt ? 4'd0 : (gnt1 != owner_q) ? 4'd1 : sat ? MAXB : burst_q + 4'd1;
    rd_tag_d = {gnt1 & ~we1, gnt0 & ~we0};
  end
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      owner_q <= 1'b0;
      burst_q <= '0;
      rd_tag_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      rd_tag_q <= rd_tag_d;
    end
  end
  assign rvalid0 = rd_tag_q[0];
  assign rvalid1 = rd_tag_q[1];
  assign rdata = mem_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table plus corner sequences and random invariant sweep for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [8:0]  adrs0, adrs1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren;
  logic [15:0] rdata, mem_data, mem_q;
  logic [8:0]  mem_address;
  logic [15:0] ram [512];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic r0, w0; logic [8:0] a0; logic [15:0] d0;
    logic r1, w1; logic [8:0] a1; logic [15:0] d1;
    logic g0, g1, wr; logic [8:0] ad; logic [15:0] md;
    logic v0, v1; logic [15:0] rd;
  } vec_t;
  vec_t tv [17];
  always #5 clk = ~clk;
  mem_arbiter #(.MAX_BURST(4)) dut (
    .cpu_clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .adrs0(adrs0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .adrs1(adrs1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r0, w0, input logic [8:0] a0, input logic [15:0] d0,
                       input logic r1, w1, input logic [8:0] a1, input logic [15:0] d1);
    req0 = r0; we0 = w0; adrs0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; adrs1 = a1; wdata1 = d1;
  endtask
  task automatic step(input logic r0, w0, input logic [8:0] a0, input logic [15:0] d0,
                      input logic r1, w1, input logic [8:0] a1, input logic [15:0] d1);
    @(negedge clk);
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #2;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_gnt0"}, 32'(gnt0), 0);
    chk({name, "_gnt1"}, 32'(gnt1), 0);
    chk({name, "_wren"}, 32'(mem_wren), 0);
    chk({name, "_addr"}, 32'(mem_address), 0);
    chk({name, "_data"}, 32'(mem_data), 0);
    chk({name, "_rv0"}, 32'(rvalid0), 0);
    chk({name, "_rv1"}, 32'(rvalid1), 0);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = '0;
    ram[9'h010] = 16'hBEEF;
    rst = 1'b1;
    drive(1, 1, 9'h055, 16'h7777, 1, 0, 9'h0AA, 16'h3333);
    #2;
    chk_idle("rst_async");
    @(negedge clk); @(negedge clk); #2;
    chk_idle("rst_held");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 9'h001, 0, 1, 0, 9'h002, 0);
    #2;
    chk("first_after_rst_gnt0", 32'(gnt0), 1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      drive(1, 0, 9'(i), 0, 1, 0, 9'(i + 100), 0);
      #2;
      chk($sformatf("contend_gnt0_%0d", i), 32'(gnt0), 32'(((i / 4) % 2) == 0));
      chk($sformatf("contend_gnt1_%0d", i), 32'(gnt1), 32'(((i / 4) % 2) == 1));
      chk($sformatf("contend_rvboth_%0d", i), 32'(rvalid0 & rvalid1), 0);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      drive(1, 0, 9'h010, 0, 0, 0, 0, 0);
      #2;
      chk($sformatf("gap_pre_gnt0_%0d", i), 32'(gnt0), 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("gap_idle_gnt", 32'({gnt0, gnt1}), 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 9'h010, 0, 1, 0, 9'h1FF, 0);
      chk($sformatf("gap_post_gnt0_%0d", i), 32'(gnt0), 32'(i < 4));
      chk($sformatf("gap_post_gnt1_%0d", i), 32'(gnt1), 32'(i == 4));
    end
    tv[0]  = '{1,0,9'h010,16'h0,    0,0,9'h0,  16'h0,    1,0,0,9'h010,16'h0,    0,0,16'h0};
    tv[1]  = '{0,0,9'h0,  16'h0,    0,0,9'h0,  16'h0,    0,0,0,9'h0,  16'h0,    1,0,16'hBEEF};
    tv[2]  = '{0,0,9'h0,  16'h0,    1,1,9'h1FF,16'h1234, 0,1,1,9'h1FF,16'h1234, 0,0,16'h0};
    tv[3]  = '{0,0,9'h0,  16'h0,    1,0,9'h1FF,16'h0,    0,1,0,9'h1FF,16'h0,    0,0,16'h0};
    tv[4]  = '{0,0,9'h0,  16'h0,    0,0,9'h0,  16'h0,    0,0,0,9'h0,  16'h0,    0,1,16'h1234};
    tv[5]  = '{1,0,9'h010,16'h0,    1,0,9'h1FF,16'h0,    0,1,0,9'h1FF,16'h0,    0,0,16'h0};
    tv[6]  = '{1,0,9'h010,16'h0,    1,0,9'h1FF,16'h0,    0,1,0,9'h1FF,16'h0,    0,1,16'h1234};
    tv[7]  = tv[6];
    tv[8]  = tv[6];
    tv[9]  = '{1,0,9'h010,16'h0,    1,0,9'h1FF,16'h0,    1,0,0,9'h010,16'h0,    0,1,16'h1234};
    tv[10] = '{1,0,9'h010,16'h0,    1,0,9'h1FF,16'h0,    1,0,0,9'h010,16'h0,    1,0,16'hBEEF};
    tv[11] = '{1,1,9'h020,16'h5A5A, 1,0,9'h1FF,16'h0,    1,0,1,9'h020,16'h5A5A, 1,0,16'hBEEF};
    tv[12] = '{1,0,9'h020,16'h0,    0,0,9'h0,  16'h0,    1,0,0,9'h020,16'h0,    0,0,16'h0};
    tv[13] = '{1,0,9'h020,16'h0,    1,0,9'h1FF,16'h0,    0,1,0,9'h1FF,16'h0,    1,0,16'h5A5A};
    tv[14] = '{1,0,9'h010,16'h0,    0,0,9'h0,  16'h0,    1,0,0,9'h010,16'h0,    0,1,16'h1234};
    tv[15] = '{0,0,9'h0,  16'h0,    1,0,9'h1FF,16'h0,    0,1,0,9'h1FF,16'h0,    1,0,16'hBEEF};
    tv[16] = '{0,0,9'h0,  16'h0,    0,0,9'h0,  16'h0,    0,0,0,9'h0,  16'h0,    0,1,16'h1234};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      drive(tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0, tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
      #2;
      chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(tv[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(tv[i].g1));
      chk($sformatf("v%0d_wren", i), 32'(mem_wren), 32'(tv[i].wr));
      chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(tv[i].ad));
      chk($sformatf("v%0d_data", i), 32'(mem_data), 32'(tv[i].md));
      chk($sformatf("v%0d_rv0", i), 32'(rvalid0), 32'(tv[i].v0));
      chk($sformatf("v%0d_rv1", i), 32'(rvalid1), 32'(tv[i].v1));
      if (tv[i].v0 | tv[i].v1) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tv[i].rd));
    end
    do_reset();
    step(0, 0, 0, 0, 1, 0, 9'h1FF, 0);
    chk("midrst_pre_gnt1", 32'(gnt1), 1);
    #1 rst = 1'b1;
    #1;
    chk_idle("midrst_during");
    @(negedge clk); #2;
    chk_idle("midrst_held");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 9'h010, 0, 1, 0, 9'h1FF, 0);
    #2;
    chk("midrst_rv1_after", 32'(rvalid1), 0);
    chk("midrst_gnt0_after", 32'(gnt0), 1);
    chk("midrst_gnt1_after", 32'(gnt1), 0);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 9'($urandom), 16'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 9'($urandom), 16'($urandom));
      #2;
      chk("rand_gnt_excl", 32'(gnt0 & gnt1), 0);
      chk("rand_rv_excl", 32'(rvalid0 & rvalid1), 0);
      chk("rand_wren_gnt", 32'(mem_wren & ~(gnt0 | gnt1)), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
